// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit for EX: shift-add multiply, restoring divide, then sign fix-up.
// Latency WIDTH+2 cycles start->done (1 cycle for divide by zero); stalls the pipe while busy.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hiloRead,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]         state;
    logic [CW-1:0]      counter;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz_r;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;

    // Signed ops work on magnitudes; signs are restored in FIX.
    logic             in_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             accept;
    logic             div_zero;

    assign in_signed = ~op[0];
    assign mag_a     = (in_signed && opA[WIDTH-1]) ? -opA : opA;
    assign mag_b     = (in_signed && opB[WIDTH-1]) ? -opB : opB;
    assign accept    = (state == S_IDLE || state == S_DONE) && start && !flush;
    assign div_zero  = op[1] && (opB == '0);

    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] step_next;

    assign acc_hi  = acc[2*WIDTH-1:WIDTH];
    assign acc_lo  = acc[WIDTH-1:0];
    assign mul_sum = {1'b0, acc_hi} + {1'b0, operand};
    assign rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, operand};

    always_comb begin
        step_next = acc;
        if (is_div) begin
            // MSB of the trial difference set means the subtraction went negative: restore.
            if (trial[WIDTH])
                step_next = {rem_sh[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
            else
                step_next = {trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            if (acc_lo[0])
                step_next = {mul_sum, acc_lo[WIDTH-1:1]};
            else
                step_next = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = neg_res ? -acc : acc;
    assign quot_fix = neg_res ? -acc_lo : acc_lo;
    assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            counter <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_r    <= 1'b0;
            operand <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        is_div  <= op[1];
                        neg_res <= in_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        neg_rem <= in_signed && opA[WIDTH-1];
                        operand <= op[1] ? mag_b : mag_a;
                        acc     <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        counter <= CW'(WIDTH - 1);
                        dz_r    <= div_zero;
                        state   <= div_zero ? S_DONE : S_RUN;
                    end else begin
                        dz_r  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc     <= step_next;
                        counter <= counter - CW'(1);
                        if (counter == '0)
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        hi    <= is_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
                        lo    <= is_div ? quot_fix : prod_fix[WIDTH-1:0];
                        dz_r  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state == S_RUN) || (state == S_FIX);
    assign stall     = busy && (start || hiloRead);
    assign done      = (state == S_DONE);
    assign divByZero = (state == S_DONE) && dz_r;
endmodule
